// File: rtl/vc_pkg.sv
// rtl/vc_pkg.sv - shared constants and VC state encoding for the VC allocator
package vc_pkg;

    localparam int NUM_REQ  = 4;
    localparam int NUM_VC   = 4;
    localparam int VC_IDX_W = 2;
    localparam int CREDITS  = 4;
    localparam int CRED_W   = 3;

    localparam logic [1:0] VC_FREE   = 2'b00;
    localparam logic [1:0] VC_ACTIVE = 2'b01;
    localparam logic [1:0] VC_DRAIN  = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered priority pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] pidx;
    logic          found;

    // First requester at or above the pointer, wrapping around
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        win   = '0;
        pidx  = '0;
        for (int i = 0; i < N; i++) begin
            pidx = PW'((int'(ptr) + i) % N);
            if (!found && req[pidx]) begin
                found     = 1'b1;
                gnt[pidx] = 1'b1;
                win       = pidx;
            end
        end
    end

    // Pointer moves just past the winner only when a grant is actually issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/vc_allocator.sv
// rtl/vc_allocator.sv - output VC allocator with per-VC lifecycle and credit tracking
module vc_allocator
    import vc_pkg::*;
#(
    parameter int NUM_REQ  = vc_pkg::NUM_REQ,
    parameter int NUM_VC   = vc_pkg::NUM_VC,
    parameter int VC_IDX_W = vc_pkg::VC_IDX_W,
    parameter int CREDITS  = vc_pkg::CREDITS,
    parameter int CRED_W   = vc_pkg::CRED_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [VC_IDX_W-1:0] gnt_vc,
    input  logic                release_valid,
    input  logic [VC_IDX_W-1:0] release_vc,
    input  logic [NUM_VC-1:0]   flit_sent,
    input  logic [NUM_VC-1:0]   credit_ret,
    output logic [NUM_VC-1:0]   vc_set,
    output logic [NUM_VC-1:0]   vc_clr,
    output logic [NUM_VC-1:0]   vc_busy,
    output logic [NUM_VC-1:0]   vc_credit_ok,
    output logic                err
);

    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);

    logic [1:0]          state     [NUM_VC];
    logic [1:0]          state_nxt [NUM_VC];
    logic [CRED_W-1:0]   cnt       [NUM_VC];
    logic [CRED_W-1:0]   cnt_nxt   [NUM_VC];
    logic [NUM_VC-1:0]   eligible;
    logic                have_vc;
    logic [VC_IDX_W-1:0] chosen;
    logic [NUM_REQ-1:0]  arb_req;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic                arb_any;
    logic [NUM_VC-1:0]   set_nxt;
    logic [NUM_VC-1:0]   clr_nxt;
    logic                err_nxt;
    logic                dec_ok;

    // A VC is allocatable only when free and fully credited; pick the lowest one
    always_comb begin
        eligible = '0;
        have_vc  = 1'b0;
        chosen   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            eligible[v] = (state[v] == VC_FREE) && (cnt[v] == CRED_FULL);
            if (eligible[v] && !have_vc) begin
                have_vc = 1'b1;
                chosen  = VC_IDX_W'(v);
            end
        end
    end

    // Requesters already holding a grant are masked so nobody wins twice in a row
    always_comb begin
        arb_req = have_vc ? (req_valid & ~gnt) : '0;
        arb_any = |arb_gnt;
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (have_vc),
        .gnt     (arb_gnt)
    );

    // Credit update, release/drain transitions and allocation, all from pre-update state
    always_comb begin
        err_nxt = err;
        set_nxt = '0;
        clr_nxt = '0;
        dec_ok  = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            state_nxt[v] = state[v];
            cnt_nxt[v]   = cnt[v];
            dec_ok = flit_sent[v] && (cnt[v] != '0) && (state[v] != VC_FREE);
            if (flit_sent[v] && !dec_ok) begin
                err_nxt = 1'b1;
            end
            if (dec_ok && !credit_ret[v]) begin
                cnt_nxt[v] = cnt[v] - 1'b1;
            end else if (!dec_ok && credit_ret[v]) begin
                if (cnt[v] == CRED_FULL) begin
                    if (!flit_sent[v]) begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt[v] = cnt[v] + 1'b1;
                end
            end
        end

        if (release_valid) begin
            if (state[release_vc] == VC_ACTIVE) begin
                if (cnt_nxt[release_vc] == CRED_FULL) begin
                    state_nxt[release_vc] = VC_FREE;
                    clr_nxt[release_vc]   = 1'b1;
                end else begin
                    state_nxt[release_vc] = VC_DRAIN;
                end
            end else begin
                err_nxt = 1'b1;
            end
        end

        for (int v = 0; v < NUM_VC; v++) begin
            if (state[v] == VC_DRAIN && cnt_nxt[v] == CRED_FULL) begin
                state_nxt[v] = VC_FREE;
                clr_nxt[v]   = 1'b1;
            end
        end

        if (arb_any) begin
            state_nxt[chosen] = VC_ACTIVE;
            set_nxt[chosen]   = 1'b1;
        end
    end

    // Register VC state, credits, grant and the single-cycle status-flop pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state[v] <= VC_FREE;
                cnt[v]   <= CRED_FULL;
            end
            gnt    <= '0;
            gnt_vc <= '0;
            vc_set <= '0;
            vc_clr <= '0;
            err    <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                state[v] <= state_nxt[v];
                cnt[v]   <= cnt_nxt[v];
            end
            gnt    <= arb_gnt;
            gnt_vc <= arb_any ? chosen : '0;
            vc_set <= set_nxt;
            vc_clr <= clr_nxt;
            err    <= err_nxt;
        end
    end

    // Status exported to switch allocation
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_busy[v]      = (state[v] != VC_FREE);
            vc_credit_ok[v] = (cnt[v] != '0);
        end
    end

endmodule

// File: tb/tb_vc_allocator.sv
// tb/tb_vc_allocator.sv - directed self-checking bench for vc_allocator
module tb_vc_allocator;

    logic       clk;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] gnt;
    logic [1:0] gnt_vc;
    logic       release_valid;
    logic [1:0] release_vc;
    logic [3:0] flit_sent;
    logic [3:0] credit_ret;
    logic [3:0] vc_set;
    logic [3:0] vc_clr;
    logic [3:0] vc_busy;
    logic [3:0] vc_credit_ok;
    logic       err;

    int tests_run;
    int tests_failed;

    vc_allocator dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .gnt           (gnt),
        .gnt_vc        (gnt_vc),
        .release_valid (release_valid),
        .release_vc    (release_vc),
        .flit_sent     (flit_sent),
        .credit_ret    (credit_ret),
        .vc_set        (vc_set),
        .vc_clr        (vc_clr),
        .vc_busy       (vc_busy),
        .vc_credit_ok  (vc_credit_ok),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid     = 4'b0000;
        release_valid = 1'b0;
        release_vc    = 2'd0;
        flit_sent     = 4'b0000;
        credit_ret    = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        idle_inputs();
        step();
        step();
        check("rst_busy",     32'(vc_busy),      32'h0);
        check("rst_cred_ok",  32'(vc_credit_ok), 32'hF);
        check("rst_gnt",      32'(gnt),          32'h0);
        check("rst_gnt_vc",   32'(gnt_vc),       32'h0);
        check("rst_set_clr",  32'({vc_set, vc_clr}), 32'h0);
        check("rst_err",      32'(err),          32'h0);
        reset = 1'b0;
        step();

        // single request from requester 2 takes VC0 one cycle later
        req_valid = 4'b0100;
        step();
        check("single_gnt",    32'(gnt),     32'h4);
        check("single_gnt_vc", 32'(gnt_vc),  32'h0);
        check("single_set",    32'(vc_set),  32'h1);
        check("single_busy",   32'(vc_busy), 32'h1);
        req_valid = 4'b0000;
        step();
        check("single_gnt_drop", 32'(gnt),    32'h0);
        check("single_set_drop", 32'(vc_set), 32'h0);

        // requester 0 takes VC1 so VC0 and VC1 are active, then async reset
        req_valid = 4'b0001;
        step();
        check("pre_rst_gnt_vc", 32'(gnt_vc),  32'h1);
        check("pre_rst_busy",   32'(vc_busy), 32'h3);
        req_valid = 4'b0000;
        reset = 1'b1;
        #1;
        check("async_busy",    32'(vc_busy),      32'h0);
        check("async_gnt",     32'(gnt),          32'h0);
        check("async_gnt_vc",  32'(gnt_vc),       32'h0);
        check("async_cred_ok", 32'(vc_credit_ok), 32'hF);
        check("async_clr",     32'(vc_clr),       32'h0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_clr", 32'(vc_clr), 32'h0);

        // round robin over four requesters and four free VCs
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rr_gnt%0d", i),    32'(gnt),    32'(1 << i));
            check($sformatf("rr_gnt_vc%0d", i), 32'(gnt_vc), 32'(i));
            check($sformatf("rr_set%0d", i),    32'(vc_set), 32'(1 << i));
            req_valid[i] = 1'b0;
        end
        check("rr_all_busy", 32'(vc_busy), 32'hF);
        req_valid = 4'b0001;
        step();
        check("rr_full_no_gnt", 32'(gnt),    32'h0);
        check("rr_full_no_set", 32'(vc_set), 32'h0);

        // drain on VC2 while requester 0 keeps waiting
        flit_sent = 4'b0100;
        step();
        step();
        flit_sent = 4'b0000;
        check("drain_cred_ok", 32'(vc_credit_ok), 32'hF);
        release_valid = 1'b1;
        release_vc    = 2'd2;
        step();
        release_valid = 1'b0;
        check("drain_busy",   32'(vc_busy[2]), 32'h1);
        check("drain_no_clr", 32'(vc_clr),     32'h0);
        credit_ret = 4'b0100;
        step();
        check("drain_mid_clr",  32'(vc_clr),     32'h0);
        check("drain_mid_busy", 32'(vc_busy[2]), 32'h1);
        step();
        credit_ret = 4'b0000;
        check("drain_clr",      32'(vc_clr),     32'h4);
        check("drain_free",     32'(vc_busy[2]), 32'h0);
        check("drain_no_gnt",   32'(gnt),        32'h0);
        step();
        check("regrant_gnt",    32'(gnt),    32'h1);
        check("regrant_gnt_vc", 32'(gnt_vc), 32'h2);
        check("regrant_set",    32'(vc_set), 32'h4);
        check("regrant_clr",    32'(vc_clr), 32'h0);
        req_valid = 4'b0000;
        check("no_err_yet", 32'(err), 32'h0);

        // flit and credit on VC1 in one cycle leave the count at 3
        flit_sent = 4'b0010;
        step();
        credit_ret = 4'b0010;
        step();
        flit_sent  = 4'b0000;
        credit_ret = 4'b0000;
        release_valid = 1'b1;
        release_vc    = 2'd1;
        step();
        release_valid = 1'b0;
        check("same_cyc_drain", 32'(vc_busy[1]), 32'h1);
        check("same_cyc_noclr", 32'(vc_clr),     32'h0);
        credit_ret = 4'b0010;
        step();
        credit_ret = 4'b0000;
        check("same_cyc_clr",  32'(vc_clr),     32'h2);
        check("same_cyc_free", 32'(vc_busy[1]), 32'h0);
        check("same_cyc_err",  32'(err),        32'h0);

        // requester 1 reclaims VC1, leaving every VC active
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        check("reclaim_gnt_vc", 32'(gnt_vc),  32'h1);
        check("reclaim_busy",   32'(vc_busy), 32'hF);

        // release VC0 in the same cycle requester 3 asks
        release_valid = 1'b1;
        release_vc    = 2'd0;
        req_valid     = 4'b1000;
        step();
        release_valid = 1'b0;
        check("rel_req_no_gnt", 32'(gnt),     32'h0);
        check("rel_req_clr",    32'(vc_clr),  32'h1);
        check("rel_req_busy",   32'(vc_busy), 32'hE);
        step();
        req_valid = 4'b0000;
        check("rel_req_gnt",    32'(gnt),    32'h8);
        check("rel_req_gnt_vc", 32'(gnt_vc), 32'h0);
        check("rel_req_set",    32'(vc_set), 32'h1);

        // flit_sent at count 0 on VC3
        flit_sent = 4'b1000;
        for (int i = 0; i < 4; i++) step();
        flit_sent = 4'b0000;
        check("cnt0_cred_ok", 32'(vc_credit_ok[3]), 32'h0);
        check("cnt0_no_err",  32'(err),             32'h0);
        flit_sent = 4'b1000;
        step();
        flit_sent = 4'b0000;
        check("cnt0_err",        32'(err),             32'h1);
        check("cnt0_stays_zero", 32'(vc_credit_ok[3]), 32'h0);
        step();
        step();
        check("err_sticky", 32'(err), 32'h1);
        do_reset();
        check("err_cleared", 32'(err), 32'h0);

        // release of a FREE VC
        release_valid = 1'b1;
        release_vc    = 2'd2;
        step();
        release_valid = 1'b0;
        check("rel_free_err",  32'(err),    32'h1);
        check("rel_free_clr",  32'(vc_clr), 32'h0);
        check("rel_free_busy", 32'(vc_busy), 32'h0);
        do_reset();

        // credit return at full count saturates; VC0 must still be allocatable
        credit_ret = 4'b0001;
        step();
        credit_ret = 4'b0000;
        check("sat_err", 32'(err), 32'h1);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        check("sat_gnt",    32'(gnt),    32'h4);
        check("sat_gnt_vc", 32'(gnt_vc), 32'h0);
        step();
        check("sat_err_sticky", 32'(err), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
